// File: rtl/oven_cook_timer.sv
// Cook-duration countdown timer: MM:SS in BCD, counts down once per second
// from an internal prescaler and raises done/alarm when it reaches 00:00.
module oven_cook_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] set_min_tens,
  input  logic [3:0] set_min_ones,
  input  logic [3:0] set_sec_tens,
  input  logic [3:0] set_sec_ones,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t        state;
  logic [15:0]   digits;
  logic [PW-1:0] presc;

  // Clamp out-of-range user digits so the display never shows non-BCD.
  function automatic logic [15:0] clamp_set(input logic [3:0] mt, input logic [3:0] mo,
                                            input logic [3:0] st, input logic [3:0] so);
    logic [3:0] a, b, c, d;
    a = (mt > 4'd9) ? 4'd9 : mt;
    b = (mo > 4'd9) ? 4'd9 : mo;
    c = (st > 4'd5) ? 4'd5 : st;
    d = (so > 4'd9) ? 4'd9 : so;
    return {a, b, c, d};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = d;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // A strobe that is ignored in the current state lets the next-lower one act.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset || cancel) begin
      state   <= IDLE;
      digits  <= 16'h0000;
      presc   <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else if (load && state != RUNNING) begin
      state   <= IDLE;
      digits  <= clamp_set(set_min_tens, set_min_ones, set_sec_tens, set_sec_ones);
      presc   <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      case (state)
        RUNNING: begin
          if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (presc == LAST_TICK) begin
            presc <= '0;
            if (digits == 16'h0001) begin
              digits  <= 16'h0000;
              state   <= DONE;
              running <= 1'b0;
              alarm   <= 1'b1;
              done    <= 1'b1;
            end else begin
              digits <= bcd_dec(digits);
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        IDLE: begin
          if (start && digits != 16'h0000) begin
            state   <= RUNNING;
            running <= 1'b1;
            presc   <= '0;
          end
        end
        PAUSED: begin
          // Resume keeps the partial second already counted.
          if (start && digits != 16'h0000) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign min_tens = digits[15:12];
  assign min_ones = digits[11:8];
  assign sec_tens = digits[7:4];
  assign sec_ones = digits[3:0];

endmodule

// File: tb/tb_oven_cook_timer.sv
// Scoreboard bench for oven_cook_timer: a seconds-based reference model
// predicts every cycle's outputs, a monitor compares them on the falling edge.
module tb_oven_cook_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset, load, start, pause, cancel;
  logic [3:0] set_min_tens, set_min_ones, set_sec_tens, set_sec_ones;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, alarm;

  oven_cook_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .load(load),
    .set_min_tens(set_min_tens), .set_min_ones(set_min_ones),
    .set_sec_tens(set_sec_tens), .set_sec_ones(set_sec_ones),
    .start(start), .pause(pause), .cancel(cancel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [3:0] mt, mo, st, so;
    logic       run, dn, alm;
  } expect_t;

  expect_t q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  // Reference model: remaining time kept as plain seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_secs = 0, m_phase = 0, m_mode = M_IDLE;
  bit m_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lim(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic modelStep(input bit r, input bit ld, input int a, input int b, input int c,
                           input int d, input bit go, input bit ps, input bit cn);
    m_done = 0;
    if (r || cn) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0;
    end else if (ld && m_mode != M_RUN) begin
      m_secs  = (lim(a, 9) * 10 + lim(b, 9)) * 60 + lim(c, 5) * 10 + lim(d, 9);
      m_mode  = M_IDLE;
      m_phase = 0;
    end else if (m_mode == M_RUN) begin
      if (ps) m_mode = M_PAUSE;
      else if (m_phase == TPS - 1) begin
        m_phase = 0;
        m_secs  = m_secs - 1;
        if (m_secs == 0) begin m_mode = M_DONE; m_done = 1; end
      end else m_phase = m_phase + 1;
    end else if (m_mode == M_IDLE) begin
      if (go && m_secs > 0) begin m_mode = M_RUN; m_phase = 0; end
    end else if (m_mode == M_PAUSE) begin
      if (go && m_secs > 0) m_mode = M_RUN;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ld, input int a, input int b, input int c,
                               input int d, input bit go, input bit ps, input bit cn);
    expect_t e;
    int mins, secs;
    @(posedge clk);
    #1;
    reset = r; load = ld; start = go; pause = ps; cancel = cn;
    set_min_tens = 4'(a); set_min_ones = 4'(b); set_sec_tens = 4'(c); set_sec_ones = 4'(d);
    modelStep(r, ld, a, b, c, d, go, ps, cn);
    mins = m_secs / 60;
    secs = m_secs % 60;
    e.tag = cyc + 1;
    e.mt  = 4'(mins / 10); e.mo = 4'(mins % 10);
    e.st  = 4'(secs / 10); e.so = 4'(secs % 10);
    e.run = (m_mode == M_RUN);
    e.alm = (m_mode == M_DONE);
    e.dn  = m_done;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doLoad(input int a, input int b, input int c, input int d);
    applyStimulus(0, 1, a, b, c, d, 0, 0, 0);
  endtask

  task automatic checkOutput(input expect_t e);
    tests++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== {e.mt, e.mo, e.st, e.so} ||
        running !== e.run || done !== e.dn || alarm !== e.alm) begin
      fails++;
      $display("[TB] FAIL cycle %0d outputs: got %h%h:%h%h run=%b done=%b alarm=%b, expected %h%h:%h%h run=%b done=%b alarm=%b",
               e.tag, min_tens, min_ones, sec_tens, sec_ones, running, done, alarm,
               e.mt, e.mo, e.st, e.so, e.run, e.dn, e.alm);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    int r;
    reset = 1; load = 0; start = 0; pause = 0; cancel = 0;
    set_min_tens = 0; set_min_ones = 0; set_sec_tens = 0; set_sec_ones = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    doLoad(0, 0, 0, 3); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(14);
    doLoad(1, 0, 0, 0); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(6);
    doLoad(0, 1, 0, 0); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(6);
    doLoad(0, 0, 0, 5); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); idle(20);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(6);
    doLoad(12, 0, 7, 9); idle(1);
    doLoad(0, 0, 0, 0); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(3);
    doLoad(0, 0, 0, 9); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(5);
    applyStimulus(0, 1, 0, 0, 3, 3, 0, 0, 1); idle(2);
    doLoad(0, 0, 0, 1); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(6);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(2);
    doLoad(0, 0, 0, 2); idle(2);
    doLoad(0, 0, 1, 0); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(12);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); idle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); idle(3);

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        if ($urandom_range(0, 3) == 0)
          doLoad($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        else
          doLoad(0, 0, $urandom_range(0, 1), $urandom_range(0, 15));
      end
      else if (r < 8)  applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      else if (r < 10) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      else if (r < 11) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      else if (r < 12) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      else             idle(1);
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
